// File: rtl/axi_txn_limiter_pkg.sv
// Shared types for the AXI/ACE outstanding-transaction limiter.
// Default request/response structs match the cache subsystem master port.
package axi_txn_limiter_pkg;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      QUIESCED
   } state_e;

   localparam int unsigned StatW = 32;
   localparam int unsigned IdW   = 4;
   localparam int unsigned AddrW = 32;
   localparam int unsigned DataW = 64;

   typedef struct packed {
      logic [IdW-1:0]   id;
      logic [AddrW-1:0] addr;
      logic [7:0]       len;
      logic [2:0]       size;
      logic [1:0]       burst;
      logic [1:0]       domain;
      logic [3:0]       snoop;
      logic [1:0]       bar;
   } ax_chan_t;

   typedef struct packed {
      logic [DataW-1:0]   data;
      logic [DataW/8-1:0] strb;
      logic               last;
   } w_chan_t;

   typedef struct packed {
      logic [IdW-1:0] id;
      logic [1:0]     resp;
   } b_chan_t;

   typedef struct packed {
      logic [IdW-1:0]   id;
      logic [DataW-1:0] data;
      logic [3:0]       resp;
      logic             last;
   } r_chan_t;

   typedef struct packed {
      logic [AddrW-1:0] addr;
      logic [3:0]       snoop;
      logic [2:0]       prot;
   } ac_chan_t;

   typedef struct packed {
      logic [DataW-1:0] data;
      logic             last;
   } cd_chan_t;

   typedef struct packed {
      ax_chan_t   aw;
      logic       aw_valid;
      w_chan_t    w;
      logic       w_valid;
      logic       b_ready;
      ax_chan_t   ar;
      logic       ar_valid;
      logic       r_ready;
      logic       wack;
      logic       rack;
      logic       ac_ready;
      logic [4:0] cr_resp;
      logic       cr_valid;
      cd_chan_t   cd;
      logic       cd_valid;
   } req_t;

   typedef struct packed {
      logic     aw_ready;
      logic     ar_ready;
      logic     w_ready;
      b_chan_t  b;
      logic     b_valid;
      r_chan_t  r;
      logic     r_valid;
      ac_chan_t ac;
      logic     ac_valid;
      logic     cr_ready;
      logic     cd_ready;
   } rsp_t;

   function automatic logic [StatW-1:0] sat_inc(input logic [StatW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/axi_txn_counter.sv
// Outstanding-transaction counter with full/zero flags.
// A decrement at zero holds the count and raises underflow.
module axi_txn_counter #(
   parameter int unsigned Max = 4,
   parameter int unsigned W   = $clog2(Max + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         full,
   output logic         zero,
   output logic         underflow
);

   logic [W-1:0] cnt_q;

   assign cnt       = cnt_q;
   assign full      = (cnt_q >= W'(Max));
   assign zero      = (cnt_q == '0);
   assign underflow = dec & ~inc & zero;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (inc & ~dec & ~full) begin
         cnt_q <= cnt_q + 1'b1;
      end else if (dec & ~inc & ~zero) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/axi_txn_limiter.sv
// Caps outstanding AXI/ACE reads and writes with a drain/quiesce handshake.
// Define AXI_TXN_LIMITER_STATS_EN for the AR/AW stall-cycle counters.
module axi_txn_limiter
   import axi_txn_limiter_pkg::*;
#(
   parameter int unsigned MaxReads  = 4,
   parameter int unsigned MaxWrites = 4,
   parameter type axi_req_t = req_t,
   parameter type axi_rsp_t = rsp_t,
   localparam int unsigned RdCntW = $clog2(MaxReads + 1),
   localparam int unsigned WrCntW = $clog2(MaxWrites + 1)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              drain_req_i,
   output logic              drain_ack_o,
   output logic              idle_o,
   output logic [RdCntW-1:0] rd_outstanding_o,
   output logic [WrCntW-1:0] wr_outstanding_o,
   output logic              err_o,
`ifdef AXI_TXN_LIMITER_STATS_EN
   output logic [StatW-1:0]  rd_stall_cnt_o,
   output logic [StatW-1:0]  wr_stall_cnt_o,
`endif
   input  axi_req_t          slv_req_i,
   output axi_rsp_t          slv_rsp_o,
   output axi_req_t          mst_req_o,
   input  axi_rsp_t          mst_rsp_i
);

   state_e state_q, state_d;

   logic open_ar, open_aw;
   logic ar_pass, aw_pass;
   logic ar_pend_q, aw_pend_q;
   logic ar_hs, aw_hs, r_done, b_done;
   logic rd_full, rd_zero, rd_uf;
   logic wr_full, wr_zero, wr_uf;
   logic err_q;

   assign open_ar = ~rd_full & (state_q == RUN);
   assign open_aw = ~wr_full & (state_q == RUN);
   // A pending offer bypasses the gate so a presented valid is never withdrawn.
   assign ar_pass = open_ar | ar_pend_q;
   assign aw_pass = open_aw | aw_pend_q;

   always_comb begin
      mst_req_o          = slv_req_i;
      slv_rsp_o          = mst_rsp_i;
      mst_req_o.ar_valid = slv_req_i.ar_valid & ar_pass;
      mst_req_o.aw_valid = slv_req_i.aw_valid & aw_pass;
      slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & ar_pass;
      slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & aw_pass;
   end

   assign ar_hs  = slv_req_i.ar_valid & ar_pass & mst_rsp_i.ar_ready;
   assign aw_hs  = slv_req_i.aw_valid & aw_pass & mst_rsp_i.aw_ready;
   assign r_done = mst_rsp_i.r_valid & slv_req_i.r_ready & mst_rsp_i.r.last;
   assign b_done = mst_rsp_i.b_valid & slv_req_i.b_ready;

   axi_txn_counter #(
      .Max (MaxReads),
      .W   (RdCntW)
   ) u_rd_cnt (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .inc       (ar_hs),
      .dec       (r_done),
      .cnt       (rd_outstanding_o),
      .full      (rd_full),
      .zero      (rd_zero),
      .underflow (rd_uf)
   );

   axi_txn_counter #(
      .Max (MaxWrites),
      .W   (WrCntW)
   ) u_wr_cnt (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .inc       (aw_hs),
      .dec       (b_done),
      .cnt       (wr_outstanding_o),
      .full      (wr_full),
      .zero      (wr_zero),
      .underflow (wr_uf)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ar_pend_q <= 1'b0;
         aw_pend_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         if (ar_hs) begin
            ar_pend_q <= 1'b0;
         end else if (mst_req_o.ar_valid) begin
            ar_pend_q <= 1'b1;
         end
         if (aw_hs) begin
            aw_pend_q <= 1'b0;
         end else if (mst_req_o.aw_valid) begin
            aw_pend_q <= 1'b1;
         end
         err_q <= err_q | rd_uf | wr_uf;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN: begin
            if (drain_req_i) state_d = DRAIN;
         end
         DRAIN: begin
            if (!drain_req_i) begin
               state_d = RUN;
            end else if (idle_o) begin
               state_d = QUIESCED;
            end
         end
         QUIESCED: begin
            if (!drain_req_i) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   assign idle_o      = rd_zero & wr_zero & ~ar_pend_q & ~aw_pend_q;
   assign drain_ack_o = (state_q == QUIESCED);
   assign err_o       = err_q;

`ifdef AXI_TXN_LIMITER_STATS_EN
   logic [StatW-1:0] rd_stall_q, wr_stall_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rd_stall_q <= '0;
         wr_stall_q <= '0;
      end else begin
         if (slv_req_i.ar_valid & ~ar_pass) rd_stall_q <= sat_inc(rd_stall_q);
         if (slv_req_i.aw_valid & ~aw_pass) wr_stall_q <= sat_inc(wr_stall_q);
      end
   end

   assign rd_stall_cnt_o = rd_stall_q;
   assign wr_stall_cnt_o = wr_stall_q;
`endif

endmodule
